// File: rtl/stream_count_feeder_pkg.sv
// Shared pipeline globals: job state encoding and default feeder/core sizing.
package stream_count_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Largest core input-FIFO fill level at which another bot may be pushed.
    localparam int DEFAULT_ALMOST_FULL = 250;

    // Width of one per-bot result returned by the core.
    localparam int DEFAULT_COUNT_WIDTH = 6;

endpackage

// File: rtl/result_accumulator.sv
// Tracks bots in flight inside the core and accumulates the results it returns.
module result_accumulator
    import stream_count_feeder_pkg::*;
#(
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int OUTST_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_botIssued,
    input  logic                   i_resultValid,
    input  logic [COUNT_WIDTH-1:0] i_count,
    output logic [OUTST_WIDTH-1:0] o_outstanding,
    output logic [63:0]            o_sum,
    output logic [31:0]            o_resultCount,
    output logic                   o_errUnexpected
);

    logic [OUTST_WIDTH-1:0] r_outstanding;
    logic [63:0]            r_sum;
    logic [31:0]            r_resultCount;
    logic                   r_errUnexpected;

    // Start clears the job totals; otherwise results accumulate in any state
    // and in-flight bots are counted, flagging a result that has no bot behind it.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_outstanding   <= '0;
            r_sum           <= '0;
            r_resultCount   <= '0;
            r_errUnexpected <= 1'b0;
        end else if (i_clear) begin
            r_outstanding   <= '0;
            r_sum           <= '0;
            r_resultCount   <= '0;
            r_errUnexpected <= 1'b0;
        end else begin
            if (i_resultValid) begin
                r_sum         <= r_sum + 64'(i_count);
                r_resultCount <= r_resultCount + 32'd1;
            end
            case ({i_botIssued, i_resultValid})
                2'b10: r_outstanding <= r_outstanding + OUTST_WIDTH'(1);
                2'b01: begin
                    if (r_outstanding != '0) begin
                        r_outstanding <= r_outstanding - OUTST_WIDTH'(1);
                    end else begin
                        r_errUnexpected <= 1'b1;
                    end
                end
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    assign o_outstanding   = r_outstanding;
    assign o_sum           = r_sum;
    assign o_resultCount   = r_resultCount;
    assign o_errUnexpected = r_errUnexpected;

endmodule

// File: rtl/stream_count_feeder.sv
// Feeds an upstream bot stream into the counting core under FIFO-level and
// in-flight back-pressure, and reports the summed core results per job.
module stream_count_feeder
    import stream_count_feeder_pkg::*;
#(
    parameter int BOT_WIDTH   = 128,
    parameter int USEDW_WIDTH = 9,
    parameter int ALMOST_FULL = DEFAULT_ALMOST_FULL,
    parameter int COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
    parameter int OUTST_WIDTH = 12
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BOT_WIDTH-1:0]   srcBot,
    input  logic                   srcValid,
    input  logic                   srcLast,
    output logic                   srcReady,
    output logic                   coreBotValid,
    output logic [BOT_WIDTH-1:0]   coreBot,
    input  logic [USEDW_WIDTH-1:0] coreUsedw,
    input  logic                   coreResultValid,
    input  logic [COUNT_WIDTH-1:0] coreCount,
    output logic [63:0]            sum,
    output logic [31:0]            resultCount,
    output logic                   busy,
    output logic                   jobDone,
    output logic                   errUnexpected
);

    state_t                 r_state;
    logic                   r_coreBotValid;
    logic [BOT_WIDTH-1:0]   r_coreBot;
    logic                   r_busy;
    logic                   r_jobDone;

    logic [OUTST_WIDTH-1:0] w_outstanding;
    logic                   w_transfer;
    logic                   w_clear;
    logic                   w_drained;
    logic                   w_fifoRoom;
    logic                   w_outstRoom;

    // The core FIFO still has room and the in-flight counter cannot wrap.
    assign w_fifoRoom  = (coreUsedw <= USEDW_WIDTH'(ALMOST_FULL));
    assign w_outstRoom = (w_outstanding != {OUTST_WIDTH{1'b1}});
    assign srcReady    = (r_state == RUN) && w_fifoRoom && w_outstRoom;

    assign w_transfer  = srcValid && srcReady;
    assign w_clear     = (r_state == IDLE) && start;
    assign w_drained   = (w_outstanding == '0) && !r_coreBotValid;

    // Job sequencing plus the one-cycle bot register toward the core.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_coreBotValid <= 1'b0;
            r_coreBot      <= '0;
            r_busy         <= 1'b0;
            r_jobDone      <= 1'b0;
        end else begin
            r_coreBotValid <= w_transfer;
            if (w_transfer) begin
                r_coreBot <= srcBot;
            end
            r_jobDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (w_transfer && srcLast) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state   <= DONE;
                        r_busy    <= 1'b0;
                        r_jobDone <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    result_accumulator #(
        .COUNT_WIDTH(COUNT_WIDTH),
        .OUTST_WIDTH(OUTST_WIDTH)
    ) u_accumulator (
        .clock          (clock),
        .rst            (rst),
        .i_clear        (w_clear),
        .i_botIssued    (r_coreBotValid),
        .i_resultValid  (coreResultValid),
        .i_count        (coreCount),
        .o_outstanding  (w_outstanding),
        .o_sum          (sum),
        .o_resultCount  (resultCount),
        .o_errUnexpected(errUnexpected)
    );

    assign coreBotValid = r_coreBotValid;
    assign coreBot      = r_coreBot;
    assign busy         = r_busy;
    assign jobDone      = r_jobDone;

endmodule

// File: tb/tb_stream_count_feeder.sv
// Directed bench for stream_count_feeder: a default-sized instance plus a
// second instance with a 2-bit in-flight counter sharing the same inputs.
module tb_stream_count_feeder;
    import stream_count_feeder_pkg::*;

    logic         clock = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [127:0] srcBot = '0;
    logic         srcValid = 1'b0;
    logic         srcLast = 1'b0;
    logic [8:0]   coreUsedw = '0;
    logic         coreResultValid = 1'b0;
    logic [5:0]   coreCount = '0;

    logic         srcReady, coreBotValid, busy, jobDone, errUnexpected;
    logic [127:0] coreBot;
    logic [63:0]  sum;
    logic [31:0]  resultCount;

    logic         srcReady2, coreBotValid2, busy2, jobDone2, errUnexpected2;
    logic [127:0] coreBot2;
    logic [63:0]  sum2;
    logic [31:0]  resultCount2;

    logic [11:0]  outst;
    logic [1:0]   outst2;
    state_t       state;

    int checks = 0;
    int errors = 0;

    assign outst  = dut.u_accumulator.o_outstanding;
    assign outst2 = dut2.u_accumulator.o_outstanding;
    assign state  = dut.r_state;

    stream_count_feeder dut (
        .clock(clock), .rst(rst), .start(start),
        .srcBot(srcBot), .srcValid(srcValid), .srcLast(srcLast), .srcReady(srcReady),
        .coreBotValid(coreBotValid), .coreBot(coreBot), .coreUsedw(coreUsedw),
        .coreResultValid(coreResultValid), .coreCount(coreCount),
        .sum(sum), .resultCount(resultCount), .busy(busy), .jobDone(jobDone),
        .errUnexpected(errUnexpected)
    );

    stream_count_feeder #(.OUTST_WIDTH(2)) dut2 (
        .clock(clock), .rst(rst), .start(start),
        .srcBot(srcBot), .srcValid(srcValid), .srcLast(srcLast), .srcReady(srcReady2),
        .coreBotValid(coreBotValid2), .coreBot(coreBot2), .coreUsedw(coreUsedw),
        .coreResultValid(coreResultValid), .coreCount(coreCount),
        .sum(sum2), .resultCount(resultCount2), .busy(busy2), .jobDone(jobDone2),
        .errUnexpected(errUnexpected2)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic idleInputs();
        start           = 1'b0;
        srcBot          = '0;
        srcValid        = 1'b0;
        srcLast         = 1'b0;
        coreUsedw       = '0;
        coreResultValid = 1'b0;
        coreCount       = '0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        idleInputs();
        rst = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
    endtask

    task automatic startJob();
        start = 1'b1;
        nextCycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1'b1;
        @(negedge clock);
        checks++;
        if (state !== IDLE) begin errors++; $display("[TB] FAIL reset_state got %0d exp %0d", state, IDLE); end
        checks++;
        if (srcReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_srcReady got %0b exp 0", srcReady); end
        checks++;
        if (coreBotValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_coreBotValid got %0b exp 0", coreBotValid); end
        checks++;
        if (coreBot !== 128'd0) begin errors++; $display("[TB] FAIL reset_coreBot got %0h exp 0", coreBot); end
        checks++;
        if (sum !== 64'd0) begin errors++; $display("[TB] FAIL reset_sum got %0d exp 0", sum); end
        checks++;
        if (resultCount !== 32'd0) begin errors++; $display("[TB] FAIL reset_resultCount got %0d exp 0", resultCount); end
        checks++;
        if (outst !== 12'd0) begin errors++; $display("[TB] FAIL reset_outstanding got %0d exp 0", outst); end
        checks++;
        if (busy !== 1'b0 || jobDone !== 1'b0 || errUnexpected !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags got busy=%0b jobDone=%0b err=%0b exp 0/0/0", busy, jobDone, errUnexpected);
        end
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_basic_job();
        int doneCount = 0;
        int botCount  = 0;
        doReset();
        startJob();
        for (int c = 0; c < 16; c++) begin
            srcValid        = (c < 5);
            srcBot          = 128'(c + 1);
            srcLast         = (c == 4);
            coreResultValid = (c >= 2 && c <= 6);
            coreCount       = 6'(c - 1);
            @(negedge clock);
            if (c < 5) begin
                checks++;
                if (srcReady !== 1'b1) begin errors++; $display("[TB] FAIL basic_srcReady c=%0d got %0b exp 1", c, srcReady); end
            end
            checks++;
            if (coreBotValid !== (c >= 1 && c <= 5)) begin
                errors++;
                $display("[TB] FAIL basic_coreBotValid c=%0d got %0b exp %0b", c, coreBotValid, (c >= 1 && c <= 5));
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if (coreBot !== 128'(c)) begin errors++; $display("[TB] FAIL basic_coreBot c=%0d got %0d exp %0d", c, coreBot, c); end
            end
            checks++;
            if (busy !== (c <= 7)) begin errors++; $display("[TB] FAIL basic_busy c=%0d got %0b exp %0b", c, busy, (c <= 7)); end
            checks++;
            if (jobDone !== (c == 8)) begin errors++; $display("[TB] FAIL basic_jobDone c=%0d got %0b exp %0b", c, jobDone, (c == 8)); end
            if (jobDone === 1'b1) doneCount++;
            if (coreBotValid === 1'b1) botCount++;
            nextCycle();
            idleInputs();
        end
        checks++;
        if (doneCount != 1) begin errors++; $display("[TB] FAIL basic_jobDone_pulses got %0d exp 1", doneCount); end
        checks++;
        if (botCount != 5) begin errors++; $display("[TB] FAIL basic_bot_pulses got %0d exp 5", botCount); end
        checks++;
        if (sum !== 64'd15) begin errors++; $display("[TB] FAIL basic_sum got %0d exp 15", sum); end
        checks++;
        if (resultCount !== 32'd5) begin errors++; $display("[TB] FAIL basic_resultCount got %0d exp 5", resultCount); end
        checks++;
        if (errUnexpected !== 1'b0) begin errors++; $display("[TB] FAIL basic_errUnexpected got %0b exp 0", errUnexpected); end
    endtask

    task automatic test_almost_full();
        int doneCount = 0;
        doReset();
        startJob();
        srcValid  = 1'b1;
        srcBot    = 128'hAA;
        srcLast   = 1'b1;
        coreUsedw = 9'd251;
        @(negedge clock);
        checks++;
        if (srcReady !== 1'b0) begin errors++; $display("[TB] FAIL almost_full_251 got %0b exp 0", srcReady); end
        coreUsedw = 9'd250;
        #1;
        checks++;
        if (srcReady !== 1'b1) begin errors++; $display("[TB] FAIL almost_full_250 got %0b exp 1", srcReady); end
        nextCycle();
        idleInputs();
        @(negedge clock);
        checks++;
        if (coreBotValid !== 1'b1 || coreBot !== 128'hAA) begin
            errors++;
            $display("[TB] FAIL almost_full_bot got valid=%0b bot=%0h exp 1/aa", coreBotValid, coreBot);
        end
        for (int k = 0; k < 10; k++) begin
            nextCycle();
            coreResultValid = (k == 0);
            coreCount       = 6'd9;
            @(negedge clock);
            if (jobDone === 1'b1) doneCount++;
        end
        idleInputs();
        checks++;
        if (doneCount != 1) begin errors++; $display("[TB] FAIL almost_full_jobDone got %0d exp 1", doneCount); end
        checks++;
        if (sum !== 64'd9) begin errors++; $display("[TB] FAIL almost_full_sum got %0d exp 9", sum); end
        nextCycle();
    endtask

    task automatic test_back_to_back();
        doReset();
        startJob();
        for (int c = 0; c < 12; c++) begin
            srcValid        = (c < 4);
            srcBot          = 128'(c + 1);
            srcLast         = (c == 3);
            coreResultValid = (c == 4) || (c >= 6 && c <= 8);
            coreCount       = 6'd1;
            @(negedge clock);
            if (c == 4) begin
                checks++;
                if (outst !== 12'd3 || coreBotValid !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL b2b_setup got outst=%0d valid=%0b exp 3/1", outst, coreBotValid);
                end
            end
            if (c == 5) begin
                checks++;
                if (outst !== 12'd3) begin errors++; $display("[TB] FAIL b2b_outstanding got %0d exp 3", outst); end
            end
            checks++;
            if (jobDone !== (c == 10)) begin errors++; $display("[TB] FAIL b2b_jobDone c=%0d got %0b exp %0b", c, jobDone, (c == 10)); end
            nextCycle();
            idleInputs();
        end
        checks++;
        if (sum !== 64'd4 || resultCount !== 32'd4) begin
            errors++;
            $display("[TB] FAIL b2b_totals got sum=%0d count=%0d exp 4/4", sum, resultCount);
        end
    endtask

    task automatic test_unexpected();
        doReset();
        coreResultValid = 1'b1;
        coreCount       = 6'd7;
        nextCycle();
        idleInputs();
        @(negedge clock);
        checks++;
        if (errUnexpected !== 1'b1) begin errors++; $display("[TB] FAIL unexpected_err got %0b exp 1", errUnexpected); end
        checks++;
        if (sum !== 64'd7 || resultCount !== 32'd1) begin
            errors++;
            $display("[TB] FAIL unexpected_sum got sum=%0d count=%0d exp 7/1", sum, resultCount);
        end
        checks++;
        if (outst !== 12'd0) begin errors++; $display("[TB] FAIL unexpected_outstanding got %0d exp 0", outst); end
        nextCycle();
        startJob();
        @(negedge clock);
        checks++;
        if (errUnexpected !== 1'b0 || sum !== 64'd0 || outst !== 12'd0) begin
            errors++;
            $display("[TB] FAIL unexpected_clear got err=%0b sum=%0d outst=%0d exp 0/0/0", errUnexpected, sum, outst);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL unexpected_busy got %0b exp 1", busy); end
        nextCycle();
    endtask

    task automatic test_reset_in_drain();
        int doneCount = 0;
        doReset();
        startJob();
        for (int c = 0; c < 6; c++) begin
            srcValid = (c < 4);
            srcBot   = 128'(c + 16);
            srcLast  = (c == 3);
            @(negedge clock);
            if (c == 5) begin
                checks++;
                if (outst !== 12'd4 || state !== DRAIN) begin
                    errors++;
                    $display("[TB] FAIL drain_setup got outst=%0d state=%0d exp 4/%0d", outst, state, DRAIN);
                end
            end
            if (c < 5) nextCycle();
            idleInputs();
        end
        rst = 1'b1;
        #1;
        checks++;
        if (state !== IDLE || busy !== 1'b0 || jobDone !== 1'b0 || outst !== 12'd0) begin
            errors++;
            $display("[TB] FAIL drain_reset got state=%0d busy=%0b jobDone=%0b outst=%0d exp 0/0/0/0", state, busy, jobDone, outst);
        end
        checks++;
        if (coreBot !== 128'd0 || coreBotValid !== 1'b0 || srcReady !== 1'b0) begin
            errors++;
            $display("[TB] FAIL drain_reset_io got bot=%0h valid=%0b ready=%0b exp 0/0/0", coreBot, coreBotValid, srcReady);
        end
        repeat (2) @(posedge clock);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (jobDone === 1'b1) doneCount++;
            if (k == 0) begin
                checks++;
                if (state !== IDLE) begin errors++; $display("[TB] FAIL drain_release_state got %0d exp %0d", state, IDLE); end
            end
        end
        checks++;
        if (doneCount != 0) begin errors++; $display("[TB] FAIL drain_no_jobDone got %0d exp 0", doneCount); end
        nextCycle();
    endtask

    task automatic test_outst_limit();
        doReset();
        startJob();
        for (int c = 0; c < 10; c++) begin
            srcValid        = (c < 3) || (c >= 4);
            srcBot          = 128'(c);
            srcLast         = (c >= 4);
            coreResultValid = (c == 7);
            coreCount       = 6'd1;
            @(negedge clock);
            if (c == 4) begin
                checks++;
                if (outst2 !== 2'd3) begin errors++; $display("[TB] FAIL limit_outstanding got %0d exp 3", outst2); end
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (srcReady2 !== 1'b0) begin errors++; $display("[TB] FAIL limit_blocked c=%0d got %0b exp 0", c, srcReady2); end
            end
            if (c == 8) begin
                checks++;
                if (srcReady2 !== 1'b1) begin errors++; $display("[TB] FAIL limit_released got %0b exp 1", srcReady2); end
            end
            if (c == 9) begin
                checks++;
                if (coreBotValid2 !== 1'b1 || coreBot2 !== 128'd8) begin
                    errors++;
                    $display("[TB] FAIL limit_bot got valid=%0b bot=%0d exp 1/8", coreBotValid2, coreBot2);
                end
            end
            nextCycle();
            idleInputs();
        end
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_almost_full();
        test_back_to_back();
        test_unexpected();
        test_reset_in_drain();
        test_outst_limit();
        doReset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_count_feeder.md
STREAM_COUNT_FEEDER -- requirements
Module: stream_count_feeder

Interface
REQ-001 SHALL have parameter BOT_WIDTH, default 128, bot vector width.
REQ-002 SHALL have parameter USEDW_WIDTH, default 9, core input-FIFO fill-level width.
REQ-003 SHALL have parameter ALMOST_FULL, default 250, largest fill level at which new bots are accepted.
REQ-004 SHALL have parameter COUNT_WIDTH, default 6, per-bot result width.
REQ-005 SHALL have parameter OUTST_WIDTH, default 12, width of the in-flight counter.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic on posedge clock.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-008 SHALL have port start, input, 1, one-cycle pulse that begins a job.
REQ-009 SHALL have port srcBot, input, BOT_WIDTH, upstream bot data.
REQ-010 SHALL have port srcValid, input, 1, upstream bot present.
REQ-011 SHALL have port srcLast, input, 1, marks the final bot of the job.
REQ-012 SHALL have port srcReady, output, 1, feeder accepts the upstream bot this cycle.
REQ-013 SHALL have port coreBotValid, output, 1, bot pushed into the core.
REQ-014 SHALL have port coreBot, output, BOT_WIDTH, bot data to the core.
REQ-015 SHALL have port coreUsedw, input, USEDW_WIDTH, core input-FIFO fill level.
REQ-016 SHALL have port coreResultValid, input, 1, core result strobe.
REQ-017 SHALL have port coreCount, input, COUNT_WIDTH, core result value.
REQ-018 SHALL have port sum, output, 64, running total of results for the job.
REQ-019 SHALL have port resultCount, output, 32, number of results received in the job.
REQ-020 SHALL have port busy, output, 1, high while in RUN or DRAIN.
REQ-021 SHALL have port jobDone, output, 1, one-cycle pulse at job completion.
REQ-022 SHALL have port errUnexpected, output, 1, sticky flag for a result received with nothing in flight.

Function
REQ-023 SHALL implement the states IDLE, RUN, DRAIN and DONE.
REQ-024 SHALL transition IDLE->RUN on start and, in the same edge, clear sum, resultCount, outstanding and errUnexpected.
REQ-025 SHALL ignore start in any state other than IDLE.
REQ-026 SHALL drive srcReady = (state==RUN) && (coreUsedw <= ALMOST_FULL) && (outstanding != all-ones).
REQ-027 SHALL register each transfer (srcValid && srcReady) so that coreBotValid=1 and coreBot=srcBot on the next cycle; latency is exactly 1 cycle and there is no core-side ready.
REQ-028 SHALL hold coreBotValid at 0 on every cycle without a transfer on the prior cycle; coreBot is then don't-care but holds its value.
REQ-029 SHALL transition RUN->DRAIN on a transfer with srcLast=1.
REQ-030 SHALL increment outstanding on coreBotValid and decrement it on coreResultValid; when both occur in the same cycle outstanding SHALL be unchanged.
REQ-031 SHALL transition DRAIN->DONE when outstanding==0 and coreBotValid==0.
REQ-032 SHALL transition DONE->IDLE after one cycle, with jobDone=1 only while in DONE.
REQ-033 SHALL, on coreResultValid, add zero-extended coreCount to sum (64-bit, wrapping) and add 1 to resultCount (32-bit, wrapping).
REQ-034 SHALL, on coreResultValid while outstanding==0 and coreBotValid==0, set errUnexpected, leave outstanding at 0, and still accumulate sum.
REQ-035 SHALL keep accumulating results that arrive in IDLE; sum and resultCount are cleared only by start or reset.

Reset
REQ-036 SHALL, on rst, asynchronously force: state=IDLE, srcReady=0, coreBotValid=0, coreBot=0, sum=0, resultCount=0, outstanding=0, busy=0, jobDone=0, errUnexpected=0.
REQ-037 SHALL, when reset is asserted mid-job, discard in-flight accounting without producing a jobDone pulse; the first clock edge after reset release SHALL observe the state IDLE.

Structure
REQ-038 SHALL place the state enumeration and the default ALMOST_FULL and COUNT_WIDTH values in the shared pipeline globals header.
REQ-039 SHALL implement the outstanding/accumulate logic in one sub-module, result_accumulator; the state machine and output register SHALL stay in the top level.

Verification
REQ-040 SHALL verify: start, then 5 bots with last on the 5th, coreUsedw=0, core returning counts 1,2,3,4,5 -> coreBotValid 5 times, each 1 cycle after its srcReady&&srcValid; sum=15; resultCount=5; exactly one jobDone pulse; errUnexpected=0.
REQ-041 SHALL verify: coreUsedw=251 with srcValid=1 -> srcReady=0; coreUsedw dropping to 250 -> srcReady=1 in the same cycle.
REQ-042 SHALL verify: a bot issue and a result in the same cycle with outstanding=3 -> outstanding stays 3.
REQ-043 SHALL verify: coreResultValid with count 7 in IDLE after reset -> errUnexpected=1, sum=7, outstanding=0; a following start clears all three.
REQ-044 SHALL verify: rst asserted in DRAIN with outstanding=4 -> all outputs reset immediately, with no jobDone pulse.
REQ-045 SHALL verify: OUTST_WIDTH=2 with 3 bots in flight -> srcReady=0 until a result arrives.
